// File: rtl/risc16_pkg.sv
// risc16_pkg: shared RISC-16 widths, opcode field positions, opcodes and fetch FSM states.
//   ADDR_W / INSTR_W : PC and instruction widths
//   OPC_MSB / OPC_LSB: opcode slice inside an instruction word
//   fetch_state_e    : fetch unit states RUN / HALT
package risc16_pkg;
    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 24;
    localparam int OPC_MSB = 23;
    localparam int OPC_LSB = 20;
    localparam logic [3:0] OPC_HLT = 4'h0;
    localparam logic [3:0] OPC_ADD = 4'h1;
    localparam logic [3:0] OPC_MVI = 4'hC;
    typedef enum logic {RUN, HALT} fetch_state_e;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundle between fetch unit, instruction memory, decode and redirect source.
//   imem_addr/imem_instr         : combinational instruction memory read
//   out_valid/out_ready/out_*    : registered instruction handed to decode
//   redirect_valid/redirect_pc   : restart request from downstream
//   halted/fetch_count           : status outputs
//   master = fetch unit side, slave = environment side
interface fetch_unit_if #(
    parameter int ADDR_W  = risc16_pkg::ADDR_W,
    parameter int INSTR_W = risc16_pkg::INSTR_W
);
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_instr;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               halted;
    logic [15:0]        fetch_count;
    modport master (
        output imem_addr, out_valid, out_instr, out_pc, halted, fetch_count,
        input  imem_instr, out_ready, redirect_valid, redirect_pc
    );
    modport slave (
        input  imem_addr, out_valid, out_instr, out_pc, halted, fetch_count,
        output imem_instr, out_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: RISC-16 fetch stage; owns the PC, registers fetched words for decode, handles redirect and HLT.
//   clk, rst : clock, synchronous active-high reset
//   bus      : fetch_unit_if.master (imem read, decode handshake, redirect, halted, fetch_count)
module fetch_unit #(
    parameter int               ADDR_W   = risc16_pkg::ADDR_W,
    parameter int               INSTR_W  = risc16_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    fetch_unit_if.master     bus
);
    import risc16_pkg::*;

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               out_valid_q, out_valid_d;
    logic [INSTR_W-1:0] out_instr_q, out_instr_d;
    logic [ADDR_W-1:0]  out_pc_q, out_pc_d;
    logic [15:0]        count_q, count_d;
    logic               load, accept;

    assign accept = out_valid_q && bus.out_ready;
    assign load   = (state_q == RUN) && (!out_valid_q || bus.out_ready) && !bus.redirect_valid;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;
        // Decode sampled the word, so a handshake counts even when it is flushed.
        count_d     = (accept && !(&count_q)) ? count_q + 16'd1 : count_q;
        if (bus.redirect_valid) begin
            pc_d        = bus.redirect_pc;
            out_valid_d = 1'b0;
            state_d     = RUN;
        end else if (load) begin
            out_instr_d = bus.imem_instr;
            out_pc_d    = pc_q;
            out_valid_d = 1'b1;
            pc_d        = pc_q + ADDR_W'(1);
            state_d     = (bus.imem_instr[OPC_MSB:OPC_LSB] == OPC_HLT) ? HALT : RUN;
        end else if (accept) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            pc_q        <= RESET_PC;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_pc_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
            count_q     <= count_d;
        end
    end

    assign bus.imem_addr   = pc_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_instr   = out_instr_q;
    assign bus.out_pc      = out_pc_q;
    assign bus.halted      = (state_q == HALT);
    assign bus.fetch_count = count_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven cycle vectors plus a hand-written HALT hold sequence for fetch_unit.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [23:0] mem [0:65535];

    always #5 clk = ~clk;

    fetch_unit_if bus ();
    fetch_unit dut (.clk(clk), .rst(rst), .bus(bus));

    assign bus.imem_instr = mem[bus.imem_addr];

    typedef struct {
        logic        rst, rdy, rv;
        logic [15:0] rpc;
        logic        v;
        logic [23:0] instr;
        logic [15:0] opc, addr;
        logic        h;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic rdy, logic rv, logic [15:0] rpc, logic v,
                                logic [23:0] instr, logic [15:0] opc, logic [15:0] addr,
                                logic h, logic [15:0] cnt);
        vec_t t;
        t.rst = r; t.rdy = rdy; t.rv = rv; t.rpc = rpc; t.v = v; t.instr = instr;
        t.opc = opc; t.addr = addr; t.h = h; t.cnt = cnt;
        return t;
    endfunction

    task automatic check(string name, int idx, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic check_all(int idx, vec_t t);
        check("out_valid", idx, 32'(bus.out_valid), 32'(t.v));
        check("out_instr", idx, 32'(bus.out_instr), 32'(t.instr));
        check("out_pc", idx, 32'(bus.out_pc), 32'(t.opc));
        check("imem_addr", idx, 32'(bus.imem_addr), 32'(t.addr));
        check("halted", idx, 32'(bus.halted), 32'(t.h));
        check("fetch_count", idx, 32'(bus.fetch_count), 32'(t.cnt));
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 24'h000000;
        mem[0] = 24'hc10005; mem[1] = 24'hc20003; mem[2] = 24'h130120; mem[3] = 24'h000000;
        mem[16'hFFFF] = 24'hc1000a;
        //                rst rdy rv rpc       v  instr        out_pc    addr      h  cnt
        vecs.push_back(mk(1, 1, 0, 16'h0000, 0, 24'h000000, 16'h0000, 16'h0000, 0, 16'd0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 1, 24'hc10005, 16'h0000, 16'h0001, 0, 16'd0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 1, 24'hc20003, 16'h0001, 16'h0002, 0, 16'd1));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 1, 24'h130120, 16'h0002, 16'h0003, 0, 16'd2));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 1, 24'h000000, 16'h0003, 16'h0004, 1, 16'd3));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 24'h000000, 16'h0003, 16'h0004, 1, 16'd4));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 24'h000000, 16'h0003, 16'h0004, 1, 16'd4));
        vecs.push_back(mk(0, 1, 1, 16'h0000, 0, 24'h000000, 16'h0003, 16'h0000, 0, 16'd4));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 1, 24'hc10005, 16'h0000, 16'h0001, 0, 16'd4));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 1, 24'hc20003, 16'h0001, 16'h0002, 0, 16'd5));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 24'hc20003, 16'h0001, 16'h0002, 0, 16'd5));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 24'hc20003, 16'h0001, 16'h0002, 0, 16'd5));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 24'hc20003, 16'h0001, 16'h0002, 0, 16'd5));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 1, 24'h130120, 16'h0002, 16'h0003, 0, 16'd6));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 1, 24'h000000, 16'h0003, 16'h0004, 1, 16'd7));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 24'h000000, 16'h0003, 16'h0004, 1, 16'd8));
        vecs.push_back(mk(0, 1, 1, 16'h0000, 0, 24'h000000, 16'h0003, 16'h0000, 0, 16'd8));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 24'hc10005, 16'h0000, 16'h0001, 0, 16'd8));
        vecs.push_back(mk(0, 0, 1, 16'h0002, 0, 24'hc10005, 16'h0000, 16'h0002, 0, 16'd8));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 1, 24'h130120, 16'h0002, 16'h0003, 0, 16'd8));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 1, 24'h000000, 16'h0003, 16'h0004, 1, 16'd9));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 24'h000000, 16'h0003, 16'h0004, 1, 16'd10));
        vecs.push_back(mk(0, 1, 1, 16'hFFFF, 0, 24'h000000, 16'h0003, 16'hFFFF, 0, 16'd10));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 1, 24'hc1000a, 16'hFFFF, 16'h0000, 0, 16'd10));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 1, 24'hc10005, 16'h0000, 16'h0001, 0, 16'd11));
        vecs.push_back(mk(0, 1, 1, 16'h0002, 0, 24'hc10005, 16'h0000, 16'h0002, 0, 16'd12));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 1, 24'h130120, 16'h0002, 16'h0003, 0, 16'd12));
        vecs.push_back(mk(1, 1, 1, 16'hFFFF, 0, 24'h000000, 16'h0000, 16'h0000, 0, 16'd0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 1, 24'hc10005, 16'h0000, 16'h0001, 0, 16'd0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 1, 24'hc20003, 16'h0001, 16'h0002, 0, 16'd1));

        bus.out_ready = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = '0; rst = 1'b1;
        foreach (vecs[i]) begin
            rst = vecs[i].rst;
            bus.out_ready = vecs[i].rdy;
            bus.redirect_valid = vecs[i].rv;
            bus.redirect_pc = vecs[i].rpc;
            @(posedge clk);
            #1;
            check_all(i, vecs[i]);
        end

        // Run to HLT, then hold it under backpressure and confirm the PC stays parked.
        rst = 1'b0; bus.redirect_valid = 1'b0; bus.out_ready = 1'b1;
        begin
            int n;
            n = 0;
            while (bus.halted !== 1'b1 && n < 20) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("halt_reached", 100, 32'(bus.halted), 32'd1);
        end
        check("hlt_presented", 101, 32'(bus.out_instr), 32'h000000);
        check("hlt_pc", 102, 32'(bus.out_pc), 32'h0003);
        bus.out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            check("hlt_hold_valid", 103 + k, 32'(bus.out_valid), 32'd1);
            check("hlt_hold_addr", 103 + k, 32'(bus.imem_addr), 32'h0004);
        end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("halt_valid", 110 + k, 32'(bus.out_valid), 32'd0);
            check("halt_addr", 110 + k, 32'(bus.imem_addr), 32'h0004);
            check("halt_flag", 110 + k, 32'(bus.halted), 32'd1);
        end
        check("halt_count", 120, 32'(bus.fetch_count), 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
